fib_stream: RTL and testbench
=============================

Name: fib_stream

Overview:
- Parametrised successor of the single-shot Fibonacci function block.
- Accepts an index n on an Avalon-ST sink and returns F(n) on an Avalon-ST source. F(1)=F(2)=1.
- Result width is generic. The overflow limit is detected arithmetically rather than hard-coded.
- Adds a sequence mode that streams F(1)..F(n) as one packet, with SOP/EOP and source back-pressure.

Parameters:
- DATA_W, 32: result width in bits; the carry out of the adder marks overflow.
- IDX_W, 9: width of the index field on ASI_DATA.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_n  in  1  asynchronous active-low reset.
- ASI_READY  out  1  sink ready; high only in IDLE.
- ASI_VALID  in  1  sink data valid.
- ASI_DATA  in  IDX_W  index n (unsigned).
- ASI_MODE  in  1  0 = single result, 1 = sequence packet; sampled with ASI_DATA.
- ASO_READY  in  1  source back-pressure.
- ASO_VALID  out  1  source data valid.
- ASO_DATA  out  DATA_W  Fibonacci value; 0 on an error beat.
- ASO_ERROR  out  1  error flag; valid when ASO_VALID=1.
- ASO_SOP  out  1  start of packet.
- ASO_EOP  out  1  end of packet.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RESET_n.
- Reset values: state=IDLE and all outputs 0, including ASI_READY. ASI_READY rises on the first CLK edge after RESET_n deasserts.
- Reset asserted mid-operation aborts immediately. No partial beat is emitted afterwards.
- Accept: happens on an edge with ASI_VALID & ASI_READY. On that edge:
  - latch n and mode;
  - a<=0, b<=1, cnt<=1;
  - ASI_READY<=0.
- Next state after accept:
  - CALC if mode=0 and n!=0;
  - SEQ if mode=1 and n!=0;
  - ERR if n=0.
- Iteration step (shared by CALC and SEQ): {a,b} <= {b, a+b}; cnt <= cnt+1.
  - The adder is DATA_W+1 bits wide.
  - A carry out sets ovf. The stored b is then don't-care.
- CALC state:
  - if cnt==n: ASO_DATA<=b, ASO_VALID<=1, SOP=EOP=1, ERROR=0; go to OUT;
  - else if the step overflows: go to ERR;
  - else: step.
- CALC latency: ASO_VALID is first high after accept edge + n edges (n=1 gives 1 edge). Throughput is one index at a time.
- OUT state:
  - hold ASO_* stable while ASO_READY=0;
  - on ASO_VALID & ASO_READY, clear ASO_VALID, set ASI_READY<=1, and go to IDLE.
- ERR state:
  - present one beat with ASO_VALID=1, ASO_ERROR=1, ASO_DATA=0, SOP=EOP=1;
  - in sequence mode after at least one beat, the error beat carries SOP=0;
  - on acceptance go to IDLE.
- SEQ state:
  - present b as beat cnt, with SOP=(cnt==1) and EOP=(cnt==n);
  - on acceptance: if EOP, go to IDLE; else step;
  - if the step overflows, the next beat is the error beat (EOP=1, ERROR=1, DATA=0) and the packet terminates;
  - no bubbles between beats while ASO_READY=1: one beat per cycle.
- Overflow limit: F(n) fits DATA_W. DATA_W=32 gives max n=47. DATA_W=16 gives max n=24. Any larger n, up to 2^IDX_W-1, yields an error beat.
- Inputs while ASI_READY=0: ASI_VALID is ignored; no queueing.
- ASI_READY stays 0 while a result or packet is outstanding.

Decomposition:
- Package fib_pkg:
  - state enum: IDLE, CALC, SEQ, OUT, ERR;
  - mode constants: MODE_SINGLE=1'b0, MODE_SEQ=1'b1.
- Sub-module fib_step: registered a/b/cnt iterator with load, advance, and a combinational ovf output; parametrised by DATA_W and IDX_W.
- Top-level: FSM plus Avalon-ST output register.

Test Plan:
- DATA_W=32, mode 0, n=1..47 sequentially, ASO_READY=1:
  - ASO_DATA matches the table: n=20 gives 6765, n=47 gives 2971215073;
  - ASO_ERROR=0, SOP=EOP=1;
  - ASO_VALID is high accept+n edges after acceptance.
- DATA_W=32, mode 0, error indices n=0, 48 and 0x100 → one beat each with ASO_ERROR=1, ASO_DATA=0.
- DATA_W=16 instance, mode 0:
  - n=24 → 46368, ERROR=0;
  - n=25 → ERROR=1.
- Mode 1, n=5, ASO_READY toggled 1,0,0,1,…:
  - beats are 1,1,2,3,5;
  - SOP on the first beat only, EOP on beat 5;
  - data held stable during stalls;
  - ASI_READY=0 until EOP is accepted.
- Mode 1, n=50, DATA_W=32 → 47 data beats (last = 2971215073, EOP=0), then a 48th beat with ERROR=1, DATA=0, EOP=1.
- RESET_n pulled low during CALC for n=40 → all outputs 0 immediately. After release: ASI_READY=1 one edge later, and a new n=10 returns 55.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci stream block: FSM states and request modes.
package fib_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        SEQ  = 3'd2,
        OUT  = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_SEQ    = 1'b1;

endpackage

// File: rtl/fib_step.sv
// Registered Fibonacci iterator: holds a=F(cnt-1), b=F(cnt) and exposes the
// next sum plus the adder carry, which flags that F(cnt+1) does not fit DATA_W.
module fib_step #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic [IDX_W-1:0]  cnt,
    output logic              ovf
);

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W:0]   sum_full;

    assign sum_full = {1'b0, a_q} + {1'b0, b_q};
    assign sum      = sum_full[DATA_W-1:0];
    assign ovf      = sum_full[DATA_W];
    assign b        = b_q;
    assign cnt      = cnt_q;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        if (load) begin
            a_d   = '0;
            b_d   = DATA_W'(1);
            cnt_d = IDX_W'(1);
        end else if (advance) begin
            a_d   = b_q;
            b_d   = sum_full[DATA_W-1:0];
            cnt_d = cnt_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fib_stream.sv
// Fibonacci server on Avalon-ST: single result F(n) or a packet F(1)..F(n).
// Handshake: a transfer happens on any CLK edge where VALID and READY are both high.
module fib_stream
    import fib_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 9
) (
    input  logic              CLK,
    input  logic              RESET_n,
    output logic              ASI_READY,
    input  logic              ASI_VALID,
    input  logic [IDX_W-1:0]  ASI_DATA,
    input  logic              ASI_MODE,
    input  logic              ASO_READY,
    output logic              ASO_VALID,
    output logic [DATA_W-1:0] ASO_DATA,
    output logic              ASO_ERROR,
    output logic              ASO_SOP,
    output logic              ASO_EOP
);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  n_q, n_d;
    logic              mode_q, mode_d;
    logic              asi_ready_q, asi_ready_d;
    logic              aso_valid_q, aso_valid_d;
    logic [DATA_W-1:0] aso_data_q, aso_data_d;
    logic              aso_error_q, aso_error_d;
    logic              aso_sop_q, aso_sop_d;
    logic              aso_eop_q, aso_eop_d;

    logic              step_load, step_advance;
    logic [DATA_W-1:0] step_b, step_sum;
    logic [IDX_W-1:0]  step_cnt, cnt_next;
    logic              step_ovf;
    logic              accept, beat_taken;

    fib_step #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_step (
        .clk     (CLK),
        .rst_n   (RESET_n),
        .load    (step_load),
        .advance (step_advance),
        .b       (step_b),
        .sum     (step_sum),
        .cnt     (step_cnt),
        .ovf     (step_ovf)
    );

    assign accept     = asi_ready_q & ASI_VALID;
    assign beat_taken = aso_valid_q & ASO_READY;
    assign cnt_next   = step_cnt + IDX_W'(1);

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        mode_d       = mode_q;
        asi_ready_d  = asi_ready_q;
        aso_valid_d  = aso_valid_q;
        aso_data_d   = aso_data_q;
        aso_error_d  = aso_error_q;
        aso_sop_d    = aso_sop_q;
        aso_eop_d    = aso_eop_q;
        step_load    = 1'b0;
        step_advance = 1'b0;

        case (state_q)
            IDLE: begin
                asi_ready_d = 1'b1;
                if (accept) begin
                    n_d         = ASI_DATA;
                    mode_d      = ASI_MODE;
                    step_load   = 1'b1;
                    asi_ready_d = 1'b0;
                    if (ASI_DATA == '0) begin
                        state_d     = ERR;
                        aso_valid_d = 1'b1;
                        aso_data_d  = '0;
                        aso_error_d = 1'b1;
                        aso_sop_d   = 1'b1;
                        aso_eop_d   = 1'b1;
                    end else if (ASI_MODE == MODE_SEQ) begin
                        // The first packet beat F(1)=1 is known at accept time,
                        // so it is presented straight away.
                        state_d     = SEQ;
                        aso_valid_d = 1'b1;
                        aso_data_d  = DATA_W'(1);
                        aso_error_d = 1'b0;
                        aso_sop_d   = 1'b1;
                        aso_eop_d   = (ASI_DATA == IDX_W'(1));
                    end else begin
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                if (step_cnt == n_q) begin
                    state_d     = OUT;
                    aso_valid_d = 1'b1;
                    aso_data_d  = step_b;
                    aso_error_d = 1'b0;
                    aso_sop_d   = 1'b1;
                    aso_eop_d   = 1'b1;
                end else if (step_ovf) begin
                    state_d     = ERR;
                    aso_valid_d = 1'b1;
                    aso_data_d  = '0;
                    aso_error_d = 1'b1;
                    aso_sop_d   = 1'b1;
                    aso_eop_d   = 1'b1;
                end else begin
                    step_advance = 1'b1;
                end
            end

            SEQ: begin
                if (beat_taken) begin
                    if (aso_eop_q) begin
                        state_d     = IDLE;
                        asi_ready_d = 1'b1;
                        aso_valid_d = 1'b0;
                        aso_data_d  = '0;
                        aso_error_d = 1'b0;
                        aso_sop_d   = 1'b0;
                        aso_eop_d   = 1'b0;
                    end else begin
                        // Load the next beat on the same edge so a ready sink sees one beat per cycle.
                        step_advance = 1'b1;
                        aso_sop_d    = 1'b0;
                        if (step_ovf) begin
                            state_d     = ERR;
                            aso_data_d  = '0;
                            aso_error_d = 1'b1;
                            aso_eop_d   = 1'b1;
                        end else begin
                            aso_data_d  = step_sum;
                            aso_error_d = 1'b0;
                            aso_eop_d   = (cnt_next == n_q);
                        end
                    end
                end
            end

            OUT, ERR: begin
                if (beat_taken) begin
                    state_d     = IDLE;
                    asi_ready_d = 1'b1;
                    aso_valid_d = 1'b0;
                    aso_data_d  = '0;
                    aso_error_d = 1'b0;
                    aso_sop_d   = 1'b0;
                    aso_eop_d   = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q     <= IDLE;
            n_q         <= '0;
            mode_q      <= MODE_SINGLE;
            asi_ready_q <= 1'b0;
            aso_valid_q <= 1'b0;
            aso_data_q  <= '0;
            aso_error_q <= 1'b0;
            aso_sop_q   <= 1'b0;
            aso_eop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            mode_q      <= mode_d;
            asi_ready_q <= asi_ready_d;
            aso_valid_q <= aso_valid_d;
            aso_data_q  <= aso_data_d;
            aso_error_q <= aso_error_d;
            aso_sop_q   <= aso_sop_d;
            aso_eop_q   <= aso_eop_d;
        end
    end

    assign ASI_READY = asi_ready_q;
    assign ASO_VALID = aso_valid_q;
    assign ASO_DATA  = aso_data_q;
    assign ASO_ERROR = aso_error_q;
    assign ASO_SOP   = aso_sop_q;
    assign ASO_EOP   = aso_eop_q;

endmodule

// File: tb/tb_fib_stream.sv
// Directed bench for fib_stream: 32-bit and 16-bit instances, single and packet modes.
module tb_fib_stream;

    logic        CLK = 1'b0;
    logic        RESET_n;

    logic        asi_valid32, asi_mode32, aso_ready32;
    logic [8:0]  asi_data32;
    logic        asi_ready32, aso_valid32, aso_error32, aso_sop32, aso_eop32;
    logic [31:0] aso_data32;

    logic        asi_valid16, asi_mode16, aso_ready16;
    logic [8:0]  asi_data16;
    logic        asi_ready16, aso_valid16, aso_error16, aso_sop16, aso_eop16;
    logic [15:0] aso_data16;

    logic        sel;
    logic        obs_ready, obs_valid, obs_error, obs_sop, obs_eop;
    logic [63:0] obs_data;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    fib_stream #(.DATA_W(32), .IDX_W(9)) u32 (
        .CLK       (CLK),
        .RESET_n   (RESET_n),
        .ASI_READY (asi_ready32),
        .ASI_VALID (asi_valid32),
        .ASI_DATA  (asi_data32),
        .ASI_MODE  (asi_mode32),
        .ASO_READY (aso_ready32),
        .ASO_VALID (aso_valid32),
        .ASO_DATA  (aso_data32),
        .ASO_ERROR (aso_error32),
        .ASO_SOP   (aso_sop32),
        .ASO_EOP   (aso_eop32)
    );

    fib_stream #(.DATA_W(16), .IDX_W(9)) u16 (
        .CLK       (CLK),
        .RESET_n   (RESET_n),
        .ASI_READY (asi_ready16),
        .ASI_VALID (asi_valid16),
        .ASI_DATA  (asi_data16),
        .ASI_MODE  (asi_mode16),
        .ASO_READY (aso_ready16),
        .ASO_VALID (aso_valid16),
        .ASO_DATA  (aso_data16),
        .ASO_ERROR (aso_error16),
        .ASO_SOP   (aso_sop16),
        .ASO_EOP   (aso_eop16)
    );

    assign obs_ready = sel ? asi_ready16 : asi_ready32;
    assign obs_valid = sel ? aso_valid16 : aso_valid32;
    assign obs_error = sel ? aso_error16 : aso_error32;
    assign obs_sop   = sel ? aso_sop16   : aso_sop32;
    assign obs_eop   = sel ? aso_eop16   : aso_eop32;
    assign obs_data  = sel ? {48'd0, aso_data16} : {32'd0, aso_data32};

    function automatic logic [63:0] fib(input int n);
        logic [63:0] a, b, t;
        a = 64'd0;
        b = 64'd1;
        for (int i = 1; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_in(input logic v, input int n, input logic m);
        if (sel) begin
            asi_valid16 = v;
            asi_data16  = 9'(n);
            asi_mode16  = m;
        end else begin
            asi_valid32 = v;
            asi_data32  = 9'(n);
            asi_mode32  = m;
        end
    endtask

    // Waits (bounded) for sink ready at a falling edge, then offers one request.
    task automatic accept(input int n, input logic m);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            if (obs_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("ready_timeout", 64'd0, 64'd1);
        drive_in(1'b1, n, m);
        @(posedge CLK);
        #1;
        drive_in(1'b0, 0, 1'b0);
    endtask

    task automatic run_single(input logic s, input int n, input logic exp_err, input logic [63:0] exp_data);
        int   lat;
        logic got;
        sel         = s;
        aso_ready32 = 1'b1;
        aso_ready16 = 1'b1;
        accept(n, 1'b0);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 700; i++) begin
            if (obs_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge CLK);
            #1;
            lat++;
        end
        check($sformatf("single_w%0d_n%0d_valid", s ? 16 : 32, n), 64'(got), 64'd1);
        if (!exp_err) check($sformatf("single_n%0d_latency", n), 64'(lat), 64'(n));
        check($sformatf("single_n%0d_data", n), obs_data, exp_data);
        check($sformatf("single_n%0d_error", n), 64'(obs_error), 64'(exp_err));
        check($sformatf("single_n%0d_sop", n), 64'(obs_sop), 64'd1);
        check($sformatf("single_n%0d_eop", n), 64'(obs_eop), 64'd1);
        @(posedge CLK);
        #1;
        check($sformatf("single_n%0d_valid_clr", n), 64'(obs_valid), 64'd0);
        check($sformatf("single_n%0d_asi_ready", n), 64'(obs_ready), 64'd1);
    endtask

    // Packet mode on the 32-bit instance; toggle applies the 1,0,0,1 ready pattern.
    task automatic run_seq(input int n, input logic toggle);
        logic [3:0]  pat;
        logic        done, stalled, exp_err, exp_sop, exp_eop;
        logic [63:0] prev_data, exp_d;
        int          beats, exp_beats;
        pat         = 4'b1001;
        sel         = 1'b0;
        aso_ready32 = 1'b0;
        accept(n, 1'b1);
        exp_beats = (n <= 47) ? n : 48;
        beats     = 0;
        done      = 1'b0;
        stalled   = 1'b0;
        prev_data = 64'd0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge CLK);
            aso_ready32 = toggle ? pat[c % 4] : 1'b1;
            if (obs_valid) begin
                if (stalled) check($sformatf("seq_n%0d_hold", n), obs_data, prev_data);
                check($sformatf("seq_n%0d_asi_ready_low", n), 64'(obs_ready), 64'd0);
                if (aso_ready32) begin
                    beats++;
                    if (beats <= 47 && beats <= n) begin
                        exp_d   = fib(beats);
                        exp_err = 1'b0;
                        exp_sop = (beats == 1);
                        exp_eop = (beats == n);
                    end else begin
                        exp_d   = 64'd0;
                        exp_err = 1'b1;
                        exp_sop = 1'b0;
                        exp_eop = 1'b1;
                    end
                    check($sformatf("seq_n%0d_b%0d_data", n, beats), obs_data, exp_d);
                    check($sformatf("seq_n%0d_b%0d_error", n, beats), 64'(obs_error), 64'(exp_err));
                    check($sformatf("seq_n%0d_b%0d_sop", n, beats), 64'(obs_sop), 64'(exp_sop));
                    check($sformatf("seq_n%0d_b%0d_eop", n, beats), 64'(obs_eop), 64'(exp_eop));
                    if (obs_eop) done = 1'b1;
                end
                stalled   = !aso_ready32;
                prev_data = obs_data;
            end
        end
        check($sformatf("seq_n%0d_done", n), 64'(done), 64'd1);
        check($sformatf("seq_n%0d_beats", n), 64'(beats), 64'(exp_beats));
        @(posedge CLK);
        #1;
        check($sformatf("seq_n%0d_valid_clr", n), 64'(obs_valid), 64'd0);
        check($sformatf("seq_n%0d_asi_ready", n), 64'(obs_ready), 64'd1);
        aso_ready32 = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_asi_ready"}, 64'(asi_ready32), 64'd0);
        check({tag, "_valid"}, 64'(aso_valid32), 64'd0);
        check({tag, "_data"}, 64'(aso_data32), 64'd0);
        check({tag, "_error"}, 64'(aso_error32), 64'd0);
        check({tag, "_sop"}, 64'(aso_sop32), 64'd0);
        check({tag, "_eop"}, 64'(aso_eop32), 64'd0);
    endtask

    task automatic release_reset(input string tag);
        @(negedge CLK);
        RESET_n = 1'b1;
        #1;
        check({tag, "_ready_before_edge"}, 64'(asi_ready32), 64'd0);
        @(posedge CLK);
        #1;
        check({tag, "_ready_after_edge"}, 64'(asi_ready32), 64'd1);
    endtask

    initial begin
        RESET_n = 1'b0;
        sel     = 1'b0;
        asi_valid32 = 1'b0; asi_data32 = '0; asi_mode32 = 1'b0; aso_ready32 = 1'b1;
        asi_valid16 = 1'b0; asi_data16 = '0; asi_mode16 = 1'b0; aso_ready16 = 1'b1;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge CLK);
        release_reset("init");

        // Hand-checked anchors, then the full table sweep.
        run_single(1'b0, 20, 1'b0, 64'd6765);
        run_single(1'b0, 47, 1'b0, 64'd2971215073);
        for (int n = 1; n <= 47; n++) run_single(1'b0, n, 1'b0, fib(n));

        run_single(1'b0, 0, 1'b1, 64'd0);
        run_single(1'b0, 48, 1'b1, 64'd0);
        run_single(1'b0, 256, 1'b1, 64'd0);

        run_single(1'b1, 24, 1'b0, 64'd46368);
        run_single(1'b1, 25, 1'b1, 64'd0);
        run_single(1'b1, 1, 1'b0, 64'd1);

        run_seq(5, 1'b1);
        run_seq(1, 1'b1);
        run_seq(50, 1'b0);
        run_seq(47, 1'b1);

        // Reset while a finished result is held by back-pressure.
        sel         = 1'b0;
        aso_ready32 = 1'b0;
        accept(3, 1'b0);
        repeat (5) @(posedge CLK);
        #1;
        check("stall_valid", 64'(aso_valid32), 64'd1);
        check("stall_data", 64'(aso_data32), 64'd2);
        #2;
        RESET_n = 1'b0;
        #1;
        check_all_zero("rst_out");
        aso_ready32 = 1'b1;
        release_reset("rst_out");

        // Reset during a long calculation.
        accept(40, 1'b0);
        repeat (10) @(posedge CLK);
        #2;
        RESET_n = 1'b0;
        #1;
        check_all_zero("rst_calc");
        repeat (2) @(posedge CLK);
        check_all_zero("rst_calc_hold");
        release_reset("rst_calc");
        run_single(1'b0, 10, 1'b0, 64'd55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
